// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end with a prefetch FIFO. It issues sequential fetch
// addresses to a fixed-latency synchronous instruction memory. Returned words
// are buffered together with their PCs and handed to decode over a
// valid/ready handshake. A branch redirect flushes the FIFO and every request
// still in flight, then restarts fetch at the branch target.
//
// Optional feature (compile-time macro FETCH_PERF_CNT_EN):
//   adds the saturating performance counters stall_cnt and flush_cnt.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   core_en     in   fetch enable; low pauses issue of new requests
//   branch_en   in   redirect request this cycle
//   branch_val  in   redirect target address
//   fetch_req   out  memory read strobe (combinational)
//   fetch_addr  out  memory read address (combinational)
//   fetch_data  in   memory read data, valid MEM_LAT cycles after a request
//   ins_valid   out  FIFO head valid
//   ins_ready   in   decode accepts the head
//   ins         out  head instruction, 0 when ins_valid is low
//   ins_pc      out  head instruction address, 0 when ins_valid is low
//   stall_cnt   out  (FETCH_PERF_CNT_EN) cycles with core_en=1 and no request
//   flush_cnt   out  (FETCH_PERF_CNT_EN) branches that discarded >=1 word
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int              ADDR_W   = 16,
    parameter int              INS_W    = 16,
    parameter int              DEPTH    = 4,
    parameter int              MEM_LAT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_en,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_val,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic [INS_W-1:0]  fetch_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] ins_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_reg;
    logic [MEM_LAT-1:0] pipe_valid_reg;
    logic [ADDR_W-1:0] pipe_addr_reg [MEM_LAT];

    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;

    logic [INS_W-1:0]  fifo_ins_mem [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_mem  [DEPTH];

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic [CNT_W:0]    inflight;
    logic              credit_ok;
    logic              tail_valid;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [CNT_W-1:0]  count_next;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [ADDR_W-1:0] pc_next;

    // Number of requests issued but not yet landed in the FIFO. Each one holds
    // a FIFO slot in reserve, which is what makes overflow impossible.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + {{CNT_W{1'b0}}, pipe_valid_reg[i]};
        end
    end

    // Credit uses start-of-cycle occupancy only; a pop in the same cycle does
    // not free a slot until the next cycle. A branch always has credit since
    // everything queued or in flight is being thrown away.
    assign credit_ok  = branch_en | (({1'b0, count_reg} + inflight) < (CNT_W+1)'(DEPTH));
    assign fetch_addr = branch_en ? branch_val : pc_reg;
    assign fetch_req  = core_en & credit_ok & rst_n;

    assign tail_valid = pipe_valid_reg[MEM_LAT-1];
    assign head_valid = (count_reg != '0);

    // On a branch the arriving tail word belongs to the old stream and any
    // pop is void.
    assign push = tail_valid & ~branch_en;
    assign pop  = head_valid & ins_ready & ~branch_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (branch_en) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // A paused core still takes a redirect so that resume starts at the target.
    always_comb begin
        pc_next = pc_reg;
        if (fetch_req) begin
            pc_next = fetch_addr + ADDR_W'(1);
        end else if (branch_en) begin
            pc_next = branch_val;
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= RESET_PC;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            pc_reg     <= pc_next;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // In-flight pipe: stage 0 takes the new request (which after a branch is
    // the request to the target), older stages are cleared by a branch.
    generate
        for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_addr_reg[gi]  <= '0;
                    end else begin
                        pipe_valid_reg[gi] <= fetch_req;
                        pipe_addr_reg[gi]  <= fetch_addr;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_addr_reg[gi]  <= '0;
                    end else begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1] & ~branch_en;
                        pipe_addr_reg[gi]  <= pipe_addr_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // FIFO storage carries no reset; contents are only visible through a
    // nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ins_mem[wr_ptr_reg] <= fetch_data;
            fifo_pc_mem[wr_ptr_reg]  <= pipe_addr_reg[MEM_LAT-1];
        end
    end

    assign ins_valid = head_valid;
    assign ins       = head_valid ? fifo_ins_mem[rd_ptr_reg] : '0;
    assign ins_pc    = head_valid ? fifo_pc_mem[rd_ptr_reg]  : '0;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && (count_reg == CNT_W'(DEPTH))));
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;
    logic        stall_event;
    logic        flush_event;

    assign stall_event = core_en & ~fetch_req;
    assign flush_event = branch_en & (head_valid | (inflight != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_event && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (flush_event && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Bench for fetch_queue with default parameters plus a second instance with
// RESET_PC=16'hFFFE for address wrap. Memory model returns addr ^ 16'hA5A5
// two cycles after the request. Expected words are queued when a request is
// issued and compared when they reach the FIFO head; directed checks cover
// timing, backpressure, branch flush, pause/resume and async reset.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_en;
    logic        branch_en;
    logic [15:0] branch_val;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [15:0] fetch_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins;
    logic [15:0] ins_pc;

    logic        w_branch_en = 1'b0;
    logic [15:0] w_branch_val = 16'h0000;
    logic        w_fetch_req;
    logic [15:0] w_fetch_addr;
    logic [15:0] w_fetch_data;
    logic        w_ins_valid;
    logic [15:0] w_ins;
    logic [15:0] w_ins_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, w_stall_cnt, w_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .rst_n(rst_n), .core_en(core_en),
        .branch_en(branch_en), .branch_val(branch_val),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    fetch_queue #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .core_en(core_en),
        .branch_en(w_branch_en), .branch_val(w_branch_val),
        .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr), .fetch_data(w_fetch_data),
        .ins_valid(w_ins_valid), .ins_ready(ins_ready), .ins(w_ins), .ins_pc(w_ins_pc)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
`endif
    );

    // Two-cycle synchronous memory models
    logic [15:0] mq0 = '0, mq1 = '0, wq0 = '0, wq1 = '0;
    always @(posedge clk) begin
        mq0 <= fetch_addr;
        mq1 <= mq0;
        wq0 <= w_fetch_addr;
        wq1 <= wq0;
    end
    assign fetch_data   = mq1 ^ 16'hA5A5;
    assign w_fetch_data = wq1 ^ 16'hA5A5;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic [15:0] exp_pc;
    int          nreq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample the current cycle at the falling edge and update the scoreboard.
    task automatic sample();
        logic [31:0] hd;
        logic [15:0] ea;
        @(negedge clk);
        if (ins_valid) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                hd = sb[0];
                chk("sb_ins", 32'(ins), 32'(hd[31:16]));
                chk("sb_pc", 32'(ins_pc), 32'(hd[15:0]));
            end
        end else begin
            chk("idle_ins", 32'(ins), 32'd0);
            chk("idle_pc", 32'(ins_pc), 32'd0);
        end
        if (branch_en) begin
            sb.delete();
        end else if (ins_valid && ins_ready && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (fetch_req) begin
            ea = branch_en ? branch_val : exp_pc;
            chk("req_addr", 32'(fetch_addr), 32'(ea));
            sb.push_back({ea ^ 16'hA5A5, ea});
            exp_pc = ea + 16'd1;
        end else if (branch_en) begin
            exp_pc = branch_val;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] wpc;
        rst_n      = 1'b1;
        core_en    = 1'b0;
        branch_en  = 1'b0;
        branch_val = 16'h0000;
        ins_ready  = 1'b0;
        exp_pc     = 16'h0000;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", 32'(ins), 32'd0);
        chk("rst_pc", 32'(ins_pc), 32'd0);
        chk("rst_req", 32'(fetch_req), 32'd0);
        advance();
        advance();

        // Streaming from reset, plus wrap on the second instance
        rst_n     = 1'b1;
        core_en   = 1'b1;
        ins_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            chk("t1_req", 32'(fetch_req), 32'd1);
            chk("t1_valid", 32'(ins_valid), 32'(c >= 3));
            if (c >= 3 && c <= 6) begin
                wpc = 16'hFFFE + 16'(c - 3);
                chk("t5_wrap_valid", 32'(w_ins_valid), 32'd1);
                chk("t5_wrap_pc", 32'(w_ins_pc), 32'(wpc));
                chk("t5_wrap_ins", 32'(w_ins), 32'(wpc ^ 16'hA5A5));
            end
            $display("t1 cycle %0d req=%0d addr=%h valid=%0d pc=%h ins=%h",
                     c, fetch_req, fetch_addr, ins_valid, ins_pc, ins);
            advance();
        end

        // Asynchronous reset mid-burst, no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(ins_valid), 32'd0);
        chk("t6_ins", 32'(ins), 32'd0);
        chk("t6_pc", 32'(ins_pc), 32'd0);
        chk("t6_req", 32'(fetch_req), 32'd0);
        $display("t6 async reset valid=%0d pc=%h ins=%h", ins_valid, ins_pc, ins);
        sb.delete();
        exp_pc = 16'h0000;
        advance();
        advance();

        // Backpressure from reset: exactly four requests
        rst_n     = 1'b1;
        core_en   = 1'b1;
        ins_ready = 1'b0;
        nreq      = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            chk("t2_req", 32'(fetch_req), 32'(c < 4));
            if (fetch_req) nreq++;
            if (c == 7) begin
                chk("t2_full_valid", 32'(ins_valid), 32'd1);
                chk("t2_full_pc", 32'(ins_pc), 32'd0);
            end
            $display("t2 cycle %0d req=%0d addr=%h valid=%0d pc=%h", c, fetch_req, fetch_addr, ins_valid, ins_pc);
            advance();
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        ins_ready = 1'b1;
        for (int c = 8; c < 16; c++) begin
            sample();
            if (c >= 9) chk("t2_resume_req", 32'(fetch_req), 32'd1);
            $display("t2 cycle %0d req=%0d addr=%h valid=%0d pc=%h", c, fetch_req, fetch_addr, ins_valid, ins_pc);
            advance();
        end

        // Branch with words queued and in flight
        ins_ready = 1'b0;
        sample(); advance();
        sample(); advance();
        branch_en  = 1'b1;
        branch_val = 16'h0100;
        ins_ready  = 1'b1;
        sample();
        chk("t3_br_addr", 32'(fetch_addr), 32'h0100);
        chk("t3_br_req", 32'(fetch_req), 32'd1);
        chk("t3_br_queued", 32'(ins_valid), 32'd1);
        $display("t3 branch addr=%h req=%0d", fetch_addr, fetch_req);
        advance();
        branch_en = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            if (c <= 2) chk("t3_flushed", 32'(ins_valid), 32'd0);
            if (c == 3) begin
                chk("t3_first_valid", 32'(ins_valid), 32'd1);
                chk("t3_first_pc", 32'(ins_pc), 32'h0100);
            end
            if (c == 4) chk("t3_second_pc", 32'(ins_pc), 32'h0101);
            $display("t3 branch+%0d valid=%0d pc=%h ins=%h", c, ins_valid, ins_pc, ins);
            advance();
        end

        // Pause issue for three cycles; in-flight words still land
        core_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("t4_pause_req", 32'(fetch_req), 32'd0);
            if (c >= 1) chk("t4_landing", 32'(ins_valid), 32'd1);
            $display("t4 pause %0d req=%0d valid=%0d pc=%h", c, fetch_req, ins_valid, ins_pc);
            advance();
        end
        core_en = 1'b1;
        sample();
        chk("t4_resume_req", 32'(fetch_req), 32'd1);
        chk("t4_resume_addr", 32'(fetch_addr), 32'h0105);
        chk("t4_drained", 32'(ins_valid), 32'd0);
        $display("t4 resume req=%0d addr=%h", fetch_req, fetch_addr);
        advance();

        // Drain
        core_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            advance();
        end
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        chk("end_valid", 32'(ins_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end with a prefetch FIFO. It issues sequential fetch addresses to a fixed-latency synchronous instruction memory and buffers returned words with their PCs. It hands instructions to decode over a valid/ready handshake and handles branch redirect by flushing. It sits between instruction memory and decode, and replaces the single-register fetch stage.

Parameters:
ADDR_W, 16, width of PC / fetch address
INS_W, 16, instruction word width
DEPTH, 4, prefetch FIFO entries; must be >= MEM_LAT
MEM_LAT, 2, cycles from request to fetch_data valid (1..4)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
core_en  in  1  fetch enable; low = pause issue
branch_en  in  1  redirect request this cycle
branch_val  in  ADDR_W  redirect target
fetch_req  out  1  memory read strobe (combinational)
fetch_addr  out  ADDR_W  memory read address (combinational)
fetch_data  in  INS_W  memory read data, valid MEM_LAT cycles after request
ins_valid  out  1  FIFO head valid
ins_ready  in  1  decode accepts head
ins  out  INS_W  head instruction; 0 when !ins_valid
ins_pc  out  ADDR_W  head instruction address; 0 when !ins_valid

Behaviour:
- Reset (async assert, sync-safe deassert): pc=RESET_PC, FIFO empty, in-flight pipe cleared; ins_valid=0, ins=0, ins_pc=0, fetch_req=0 while rst_n=0.
- State: pc (next address to issue), MEM_LAT-deep in-flight pipe of {valid, addr}, FIFO of {ins, pc}, count 0..DEPTH.
- fetch_addr = branch_en ? branch_val : pc.
- credit_ok = branch_en ? 1 : (count + inflight_valid) < DEPTH, evaluated on start-of-cycle values. A pop in the same cycle does not free a credit.
- fetch_req = core_en & credit_ok & rst_n. On a fetch_req cycle: pc <= fetch_addr + 1 (mod 2^ADDR_W); {1, fetch_addr} enters pipe stage 0.
- Without a fetch_req cycle, pc is held, except on branch_en with core_en=0, where pc <= branch_val.
- Timing: request in cycle t; fetch_data sampled in cycle t+MEM_LAT when the pipe tail is valid; the word is pushed at that edge. ins_valid is first high in t+MEM_LAT+1. No bypass.
- Steady state with ins_ready=1: one instruction per cycle, no bubbles.
- Pop: ins_valid & ins_ready at the edge removes the head.
- Branch (branch_en=1 in cycle t): at the edge, FIFO count=0, all in-flight valids cleared, and the tail data arriving in t is dropped. A pop in t is void. The new request to branch_val issues in t if core_en. ins_valid=0 in t+1.
- core_en=0: no new requests. In-flight words still land; FIFO and pops continue. Resume continues from pc.
- Overflow is impossible by construction. Assert (sim only) push with count==DEPTH.
- Async reset mid-operation discards all in-flight and queued words.

Optional Feature:
FETCH_PERF_CNT_EN: adds output ports stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
- stall_cnt increments each cycle with core_en=1 and fetch_req=0.
- flush_cnt increments each branch_en cycle that discards >=1 queued or in-flight word.
- Both saturate at 0xFFFFFFFF.
Without the macro these ports and counters do not exist.

Test Plan:
Use defaults. Memory model returns addr^16'hA5A5 after 2 cycles.
1. Release rst_n, core_en=1, ins_ready=1 -> fetch_addr 0,1,2,... every cycle; ins_valid high from cycle 3 on; ins_pc 0,1,2,... with ins=A5A5,A5A4,A5A7; no gaps.
2. ins_ready=0 from reset -> exactly 4 requests (0..3), then fetch_req=0, count=4; ins_ready=1 -> ins_pc 0..3 popped, requests resume at 4, and one bubble is allowed.
3. Branch with addresses 5,6 in flight and 3,4 queued, branch_val=16'h0100 -> fetch_addr=0100 same cycle, ins_valid=0 next cycle, pcs 3-6 never appear, next ins_pc=0100 three cycles after branch, then 0101.
4. core_en=0 for 3 cycles mid-stream after issuing 8 -> fetch_req=0 immediately, words 7,8 still delivered, next request address 9 on re-enable.
5. RESET_PC=16'hFFFE -> ins_pc FFFE, FFFF, 0000, 0001 (wrap).
6. rst_n pulsed low mid-burst asynchronously -> ins_valid, ins, ins_pc go 0 without a clock edge; after release fetch restarts at RESET_PC and no stale word is delivered.
